// File: rtl/lms_out_decim.sv
// Block-average decimator for LMS filter output: sums DEC samples, pushes the
// floor-rounded mean into a first-word-fall-through FIFO with a sticky overflow flag.
module lms_out_decim #(
   parameter int DAT_W = 16,
   parameter int DEC   = 8,
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [DAT_W-1:0]          din,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DAT_W-1:0]          m_data,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      ovf,
   input  logic                      clr_ovf
);
   localparam int S  = $clog2(DEC);
   localparam int L  = $clog2(DEPTH);
   localparam int AW = DAT_W + S;
   localparam logic [S-1:0] CNT_MAX = S'(DEC - 1);
   localparam logic [L:0]   FULL    = (L+1)'(DEPTH);

   logic [S-1:0]          cnt;
   logic signed [AW-1:0]  acc, sum;
   logic [DAT_W-1:0]      word;
   logic [DAT_W-1:0]      mem [DEPTH];
   logic [L-1:0]          wptr, rptr;
   logic [L:0]            lvl;
   logic                  push, pop, full, wr, drop;

   // AW bits hold any sum of DEC samples, so the shifted slice is exact floor(mean)
   assign sum  = acc + {{S{din[DAT_W-1]}}, din};
   assign word = sum[S +: DAT_W];
   assign push = en && (cnt == CNT_MAX);
   assign full = (lvl == FULL);
   assign pop  = (lvl != '0) && m_ready;
   // A full FIFO still takes the push when the head leaves on the same edge
   assign wr   = push && (!full || pop);
   assign drop = push && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         acc <= '0;
      end else if (en) begin
         if (cnt == CNT_MAX) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            acc <= sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         lvl  <= '0;
         ovf  <= 1'b0;
      end else begin
         if (wr)  wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (wr && !pop)      lvl <= lvl + 1'b1;
         else if (!wr && pop) lvl <= lvl - 1'b1;
         if (drop)         ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
      end
   end

   assign m_valid = (lvl != '0);
   assign m_data  = m_valid ? mem[rptr] : '0;
   assign level   = lvl;
endmodule

// File: tb/tb_lms_out_decim.sv
// Directed bench for lms_out_decim (DAT_W=16, DEC=8, DEPTH=16) with hand-computed
// expectations; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lms_out_decim;
   logic        clk = 1'b0;
   logic        rst, en, m_ready, clr_ovf, m_valid, ovf;
   logic [15:0] din, m_data;
   logic [4:0]  level;
   int vectors = 0;
   int miscompares = 0;

   lms_out_decim #(.DAT_W(16), .DEC(8), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .en(en), .din(din), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .level(level), .ovf(ovf),
      .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp(input logic [15:0] v);
      en = 1'b1; din = v;
      tick();
      en = 1'b0; din = '0;
   endtask

   task automatic blk(input logic [15:0] v);
      for (int i = 0; i < 8; i++) samp(v);
   endtask

   task automatic pop1();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; din = '0; m_ready = 1'b0; clr_ovf = 1'b0;
      #12;
      chk("rst_valid", m_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_data", m_data, 0);
      chk("rst_ovf", ovf, 0);
      tick();
      rst = 1'b0;
      tick();

      // basic block of 100
      for (int i = 0; i < 7; i++) samp(16'd100);
      chk("b100_pre_valid", m_valid, 0);
      samp(16'd100);
      chk("b100_valid", m_valid, 1);
      chk("b100_data", m_data, 100);
      chk("b100_level", level, 1);
      pop1();
      chk("b100_pop_level", level, 0);
      chk("b100_pop_data", m_data, 0);
      pop1();
      chk("empty_pop_level", level, 0);

      // extremes and floor rounding
      blk(16'h8000);
      chk("min_data", m_data, 16'h8000);
      pop1();
      for (int i = 0; i < 7; i++) samp(16'h0000);
      samp(16'hFFFF);
      chk("floor_m1", m_data, 16'hFFFF);
      pop1();
      blk(16'h7FFF);
      chk("max_data", m_data, 16'h7FFF);
      pop1();
      chk("ext_level", level, 0);

      // overflow: 17 blocks into a 16-deep FIFO, last one dropped
      for (int b = 1; b <= 16; b++) blk(16'(b));
      chk("ovf_full_level", level, 16);
      chk("ovf_pre_flag", ovf, 0);
      blk(16'd17);
      chk("ovf_level", level, 16);
      chk("ovf_flag", ovf, 1);
      for (int b = 1; b <= 16; b++) begin
         chk($sformatf("drain_%0d", b), m_data, b);
         pop1();
      end
      chk("drain_valid", m_valid, 0);
      chk("drain_ovf_sticky", ovf, 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("clr_ovf", ovf, 0);

      // full FIFO with concurrent push and pop on the 17th push edge
      for (int b = 101; b <= 116; b++) blk(16'(b));
      chk("cc_full_level", level, 16);
      for (int i = 0; i < 7; i++) samp(16'd117);
      m_ready = 1'b1;
      samp(16'd117);
      m_ready = 1'b0;
      chk("cc_level", level, 16);
      chk("cc_ovf", ovf, 0);
      chk("cc_head", m_data, 102);
      for (int b = 102; b <= 117; b++) begin
         chk($sformatf("cc_drain_%0d", b), m_data, b);
         pop1();
      end
      chk("cc_empty", m_valid, 0);

      // en gaps: 8 samples of 40 spread over 20 cycles
      begin
         int left = 8;
         for (int c = 20; c > 0; c--) begin
            en = (left > 0) && ((left == c) || ($urandom_range(0, 1) == 1));
            din = en ? 16'd40 : 16'hDEAD;
            if (en) left--;
            tick();
         end
         en = 1'b0; din = '0;
      end
      tick(); tick();
      chk("gap_level", level, 1);
      chk("gap_data", m_data, 40);
      pop1();
      chk("gap_empty", level, 0);

      // reset mid-block with a word already queued
      blk(16'd7);
      for (int i = 0; i < 5; i++) samp(16'd500);
      chk("mid_pre_level", level, 1);
      rst = 1'b1;
      en = 1'b1; din = 16'd500; m_ready = 1'b1; clr_ovf = 1'b1;
      #1;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_valid", m_valid, 0);
      tick();
      chk("mid_rst_hold", level, 0);
      en = 1'b0; din = '0; m_ready = 1'b0; clr_ovf = 1'b0;
      rst = 1'b0;
      tick();
      blk(16'd8);
      chk("post_rst_level", level, 1);
      chk("post_rst_data", m_data, 8);
      pop1();
      chk("post_rst_empty", m_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
